// File: rtl/hero_write_arbiter.sv
// Transaction-granular arbiter sharing one hero write bus among NUM_REQ requesters.
// Define HERO_ARB_RR_EN for round-robin winner selection; otherwise the lowest pending index wins.
module hero_write_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned MAX_BEATS = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ*4-1:0]  req_cycle_type,
  input  logic [NUM_REQ*36-1:0] req_wdat,
  input  logic [NUM_REQ-1:0]    req_clk_en,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [3:0]            hero_cycle_type,
  output logic [35:0]           hero_wdat,
  output logic                  hero_clk_en,
  input  logic                  hero_ready,
  output logic [15:0]           txn_cnt,
  output logic                  err_len,
  output logic                  err_enc
);

  localparam int unsigned HERO_WIDTH = 36;
  localparam int unsigned TYPE_W     = 4;
  localparam int unsigned TXN_W      = 16;
  localparam int unsigned OWNER_W    = $clog2(NUM_REQ);
  localparam int unsigned CNT_W      = $clog2(MAX_BEATS + 1);

  localparam logic [TYPE_W-1:0] CYC_IDLE  = TYPE_W'(0);
  localparam logic [TYPE_W-1:0] CYC_VALID = TYPE_W'(1);
  localparam logic [TYPE_W-1:0] CYC_DONE  = TYPE_W'(2);

  typedef struct packed {
    logic [TYPE_W-1:0]     cycle_type;
    logic [HERO_WIDTH-1:0] wdat;
    logic                  clk_en;
  } hero_beat_t;

  typedef enum logic {
    ST_ARB = 1'b0,
    ST_OWN = 1'b1
  } state_t;

  state_t             state, state_d;
  logic [OWNER_W-1:0] owner, owner_d;
  logic [OWNER_W-1:0] last_owner, last_owner_d;
  logic [OWNER_W-1:0] winner;
  logic [CNT_W-1:0]   beat_cnt, beat_cnt_d;
  hero_beat_t         out_q, out_d;
  hero_beat_t         own_beat;
  hero_beat_t         req_beat [NUM_REQ];
  logic [NUM_REQ-1:0] pending;
  logic               any_pending;
  logic               out_busy;
  logic               own_accept;
  logic [TXN_W-1:0]   txn_cnt_d;
  logic               err_len_d;
  logic               err_enc_d;

  // Slice the flat requester buses into per-requester beats.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
    assign req_beat[g] = {req_cycle_type[TYPE_W*g +: TYPE_W],
                          req_wdat[HERO_WIDTH*g +: HERO_WIDTH],
                          req_clk_en[g]};
    assign pending[g]  = (req_cycle_type[TYPE_W*g +: TYPE_W] != CYC_IDLE);
  end

  assign any_pending = |pending;

`ifdef HERO_ARB_RR_EN
  // Round-robin: first pending index above last_owner, wrapping.
  always_comb begin : winner_rr
    logic found;
    found  = 1'b0;
    winner = '0;
    for (int k = 1; k <= int'(NUM_REQ); k++) begin
      if (!found && pending[OWNER_W'((int'(last_owner) + k) % int'(NUM_REQ))]) begin
        winner = OWNER_W'((int'(last_owner) + k) % int'(NUM_REQ));
        found  = 1'b1;
      end
    end
  end
`else
  // Fixed priority: lowest pending index wins.
  always_comb begin : winner_fixed
    winner = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (pending[OWNER_W'(i)]) winner = OWNER_W'(i);
    end
  end

  // last_owner is still tracked in fixed-priority builds but does not steer selection.
  logic unused_last_owner;
  assign unused_last_owner = ^last_owner;
`endif

  assign own_beat   = req_beat[owner];
  assign out_busy   = (out_q.cycle_type != CYC_IDLE);
  assign own_accept = (state == ST_OWN) && (!out_busy || hero_ready);

  // Next-state, output-stage and status logic; req_ready follows hero_ready combinationally.
  always_comb begin : next_state
    state_d      = state;
    owner_d      = owner;
    last_owner_d = last_owner;
    beat_cnt_d   = beat_cnt;
    out_d        = out_q;
    txn_cnt_d    = txn_cnt;
    err_len_d    = err_len;
    err_enc_d    = err_enc;
    req_ready    = '0;

    if (out_busy && hero_ready) begin
      out_d.cycle_type = CYC_IDLE;
      if (out_q.cycle_type == CYC_DONE) txn_cnt_d = txn_cnt + TXN_W'(1);
    end

    case (state)
      ST_ARB: begin
        if (any_pending) begin
          owner_d = winner;
          state_d = ST_OWN;
        end
      end
      ST_OWN: begin
        req_ready[owner] = own_accept;
        if (own_accept) begin
          case (own_beat.cycle_type)
            CYC_IDLE: begin
            end
            CYC_VALID: begin
              out_d = own_beat;
              if (beat_cnt == CNT_W'(MAX_BEATS - 1)) begin
                // Length limit hit: close the transaction with a forced DONE.
                out_d.cycle_type = CYC_DONE;
                err_len_d        = 1'b1;
                state_d          = ST_ARB;
                last_owner_d     = owner;
                beat_cnt_d       = '0;
              end else if (beat_cnt < CNT_W'(MAX_BEATS)) begin
                beat_cnt_d = beat_cnt + CNT_W'(1);
              end
            end
            CYC_DONE: begin
              out_d        = own_beat;
              state_d      = ST_ARB;
              last_owner_d = owner;
              beat_cnt_d   = '0;
            end
            default: begin
              err_enc_d = 1'b1;
            end
          endcase
        end
      end
      default: begin
        state_d = ST_ARB;
      end
    endcase
  end

  always_ff @(posedge clk) begin : regs
    if (rst) begin
      state      <= ST_ARB;
      owner      <= '0;
      last_owner <= OWNER_W'(NUM_REQ - 1);
      beat_cnt   <= '0;
      out_q      <= '0;
      txn_cnt    <= '0;
      err_len    <= 1'b0;
      err_enc    <= 1'b0;
    end else begin
      state      <= state_d;
      owner      <= owner_d;
      last_owner <= last_owner_d;
      beat_cnt   <= beat_cnt_d;
      out_q      <= out_d;
      txn_cnt    <= txn_cnt_d;
      err_len    <= err_len_d;
      err_enc    <= err_enc_d;
    end
  end

  assign hero_cycle_type = out_q.cycle_type;
  assign hero_wdat       = out_q.wdat;
  assign hero_clk_en     = out_q.clk_en;

endmodule

// File: tb/tb_hero_write_arbiter.sv
// Directed bench for hero_write_arbiter: per-cycle vector table plus a reactive contention run.
module tb_hero_write_arbiter;

  localparam int unsigned NUM_REQ   = 4;
  localparam int unsigned MAX_BEATS = 4;

  localparam logic [35:0] N  = 36'h0;
  localparam logic [35:0] F  = 36'hF_0000_0000;
  localparam logic [35:0] DA = 36'h1_1111_1111;
  localparam logic [35:0] DB = 36'h2_2222_2222;
  localparam logic [35:0] DC = 36'h3_3333_3333;
  localparam logic [35:0] DD = 36'h4_4444_4444;
  localparam logic [35:0] V1 = 36'h5_0000_0001;
  localparam logic [35:0] V2 = 36'h5_0000_0002;
  localparam logic [35:0] V3 = 36'h5_0000_0003;
  localparam logic [35:0] V4 = 36'h5_0000_0004;
  localparam logic [35:0] V5 = 36'h5_0000_0005;
  localparam logic [35:0] V6 = 36'h5_0000_0006;
  localparam logic [35:0] X  = 36'h7_0000_00AA;
  localparam logic [35:0] Y  = 36'h7_0000_00BB;
  localparam logic [35:0] Z  = 36'hE_EEEE_EEEE;
  localparam logic [35:0] P  = 36'h8_0000_0001;
  localparam logic [35:0] P2 = 36'h8_0000_0002;
  localparam logic [35:0] Q1 = 36'h9_0000_0001;
  localparam logic [35:0] Q2 = 36'h9_0000_0002;
  localparam logic [35:0] Q3 = 36'h9_0000_0003;

  logic         clk = 1'b0;
  logic         rst;
  logic [15:0]  req_cycle_type;
  logic [143:0] req_wdat;
  logic [3:0]   req_clk_en;
  logic [3:0]   req_ready;
  logic [3:0]   hero_cycle_type;
  logic [35:0]  hero_wdat;
  logic         hero_clk_en;
  logic         hero_ready;
  logic [15:0]  txn_cnt;
  logic         err_len;
  logic         err_enc;

  hero_write_arbiter #(.NUM_REQ(NUM_REQ), .MAX_BEATS(MAX_BEATS)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_cycle_type (req_cycle_type),
    .req_wdat       (req_wdat),
    .req_clk_en     (req_clk_en),
    .req_ready      (req_ready),
    .hero_cycle_type(hero_cycle_type),
    .hero_wdat      (hero_wdat),
    .hero_clk_en    (hero_clk_en),
    .hero_ready     (hero_ready),
    .txn_cnt        (txn_cnt),
    .err_len        (err_len),
    .err_enc        (err_enc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             rst;
    logic             hr;
    logic [15:0]      types;
    logic [3:0][35:0] wdat;
    logic [3:0]       ce;
    logic [3:0]       rdy;
    logic [3:0]       ty;
    logic [35:0]      wd;
    logic             ceo;
    logic [15:0]      txn;
    logic             el;
    logic             ee;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

`ifdef HERO_ARB_RR_EN
  int exp_own [4] = '{0, 1, 3, 0};
`else
  int exp_own [4] = '{0, 0, 0, 0};
`endif

  int          phase [4];
  int          seq   [4];
  int          grants[4];
  logic [3:0]  rdy_s;
  logic [3:0]  bt_ty[$];
  logic [35:0] bt_wd[$];

  function automatic vec_t v(input logic r, input logic hr, input logic [15:0] t,
                             input logic [143:0] w, input logic [3:0] ce,
                             input logic [3:0] rdy, input logic [3:0] ty, input logic [35:0] wd,
                             input logic ceo, input logic [15:0] txn, input logic el, input logic ee);
    vec_t x;
    x.rst = r;   x.hr = hr;   x.types = t;  x.wdat = w;   x.ce = ce;
    x.rdy = rdy; x.ty = ty;   x.wd = wd;    x.ceo = ceo;  x.txn = txn;
    x.el = el;   x.ee = ee;
    return x;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [35:0] act, input logic [35:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", nm, idx, act, exp);
    end
  endtask

  initial begin
    rst            = 1'b1;
    hero_ready     = 1'b1;
    req_cycle_type = '0;
    req_wdat       = '0;
    req_clk_en     = '0;

    // Single requester 2: VALID x3 then DONE, beats on the bus at cycles 2..5.
    vecs.push_back(v(0,1,16'h0100,{N,36'h1,N,N},4'h4, 4'h0,4'd0,N,0,16'd0,0,0));
    vecs.push_back(v(0,1,16'h0100,{N,36'h1,N,N},4'h4, 4'h4,4'd0,N,0,16'd0,0,0));
    vecs.push_back(v(0,1,16'h0100,{N,36'h2,N,N},4'h0, 4'h4,4'd1,36'h1,1,16'd0,0,0));
    vecs.push_back(v(0,1,16'h0100,{N,36'h3,N,N},4'h4, 4'h4,4'd1,36'h2,0,16'd0,0,0));
    vecs.push_back(v(0,1,16'h0200,{N,F,N,N},4'h4,     4'h4,4'd1,36'h3,1,16'd0,0,0));
    vecs.push_back(v(0,1,16'h0000,{N,N,N,N},4'h0,     4'h0,4'd2,F,1,16'd0,0,0));
    vecs.push_back(v(1,1,16'h0000,{N,N,N,N},4'h0,     4'h0,4'd0,F,1,16'd1,0,0));
    // Backpressure on requester 1; output DONE also held while hero_ready is low.
    vecs.push_back(v(0,1,16'h0010,{N,N,DA,N},4'h2, 4'h0,4'd0,N,0,16'd0,0,0));
    vecs.push_back(v(0,1,16'h0010,{N,N,DA,N},4'h2, 4'h2,4'd0,N,0,16'd0,0,0));
    vecs.push_back(v(0,1,16'h0010,{N,N,DB,N},4'h2, 4'h2,4'd1,DA,1,16'd0,0,0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(v(0,0,16'h0010,{N,N,DC,N},4'h2, 4'h0,4'd1,DB,1,16'd0,0,0));
    vecs.push_back(v(0,1,16'h0010,{N,N,DC,N},4'h2, 4'h2,4'd1,DB,1,16'd0,0,0));
    vecs.push_back(v(0,1,16'h0020,{N,N,DD,N},4'h2, 4'h2,4'd1,DC,1,16'd0,0,0));
    vecs.push_back(v(0,0,16'h0000,{N,N,N,N},4'h0,  4'h0,4'd2,DD,1,16'd0,0,0));
    vecs.push_back(v(0,1,16'h0000,{N,N,N,N},4'h0,  4'h0,4'd2,DD,1,16'd0,0,0));
    vecs.push_back(v(1,1,16'h0000,{N,N,N,N},4'h0,  4'h0,4'd0,DD,1,16'd1,0,0));
    // Length limit: 4th VALID from requester 3 goes out as DONE and sets err_len.
    vecs.push_back(v(0,1,16'h1000,{V1,N,N,N},4'h8, 4'h0,4'd0,N,0,16'd0,0,0));
    vecs.push_back(v(0,1,16'h1000,{V1,N,N,N},4'h8, 4'h8,4'd0,N,0,16'd0,0,0));
    vecs.push_back(v(0,1,16'h1000,{V2,N,N,N},4'h8, 4'h8,4'd1,V1,1,16'd0,0,0));
    vecs.push_back(v(0,1,16'h1000,{V3,N,N,N},4'h8, 4'h8,4'd1,V2,1,16'd0,0,0));
    vecs.push_back(v(0,1,16'h1000,{V4,N,N,N},4'h8, 4'h8,4'd1,V3,1,16'd0,0,0));
    vecs.push_back(v(0,1,16'h1000,{V5,N,N,N},4'h8, 4'h0,4'd2,V4,1,16'd0,1,0));
    vecs.push_back(v(0,1,16'h1000,{V5,N,N,N},4'h8, 4'h8,4'd0,V4,1,16'd1,1,0));
    vecs.push_back(v(0,1,16'h1000,{V6,N,N,N},4'h8, 4'h8,4'd1,V5,1,16'd1,1,0));
    vecs.push_back(v(0,1,16'h0000,{N,N,N,N},4'h0,  4'h8,4'd1,V6,1,16'd1,1,0));
    vecs.push_back(v(1,1,16'h0000,{N,N,N,N},4'h0,  4'h8,4'd0,V6,1,16'd1,1,0));
    // Illegal code 3 from owner 0 is dropped; non-owner code 5 never flags.
    vecs.push_back(v(0,1,16'h0051,{N,N,N,X},4'h1, 4'h0,4'd0,N,0,16'd0,0,0));
    vecs.push_back(v(0,1,16'h0051,{N,N,N,X},4'h1, 4'h1,4'd0,N,0,16'd0,0,0));
    vecs.push_back(v(0,1,16'h0003,{N,N,N,Z},4'h1, 4'h1,4'd1,X,1,16'd0,0,0));
    vecs.push_back(v(0,1,16'h0002,{N,N,N,Y},4'h0, 4'h1,4'd0,X,1,16'd0,0,1));
    vecs.push_back(v(0,1,16'h0000,{N,N,N,N},4'h0, 4'h0,4'd2,Y,0,16'd0,0,1));
    vecs.push_back(v(0,1,16'h0000,{N,N,N,N},4'h0, 4'h0,4'd0,Y,0,16'd1,0,1));
    // Reset mid-transaction of requester 2; requester 0 wins first afterwards.
    vecs.push_back(v(0,1,16'h0100,{N,Q1,N,N},4'h4, 4'h0,4'd0,Y,0,16'd1,0,1));
    vecs.push_back(v(0,1,16'h0101,{N,Q1,N,P},4'h5, 4'h4,4'd0,Y,0,16'd1,0,1));
    vecs.push_back(v(0,1,16'h0101,{N,Q2,N,P},4'h5, 4'h4,4'd1,Q1,1,16'd1,0,1));
    vecs.push_back(v(1,1,16'h0101,{N,Q3,N,P},4'h5, 4'h4,4'd1,Q2,1,16'd1,0,1));
    vecs.push_back(v(0,1,16'h0101,{N,Q3,N,P},4'h5, 4'h0,4'd0,N,0,16'd0,0,0));
    vecs.push_back(v(0,1,16'h0101,{N,Q3,N,P},4'h5, 4'h1,4'd0,N,0,16'd0,0,0));
    vecs.push_back(v(0,1,16'h0102,{N,Q3,N,P2},4'h5, 4'h1,4'd1,P,1,16'd0,0,0));
    vecs.push_back(v(0,1,16'h0100,{N,Q3,N,N},4'h4, 4'h0,4'd2,P2,1,16'd0,0,0));
    vecs.push_back(v(0,1,16'h0100,{N,Q3,N,N},4'h4, 4'h4,4'd0,P2,1,16'd1,0,0));

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int k = 0; k < vecs.size(); k++) begin
      rst            = vecs[k].rst;
      hero_ready     = vecs[k].hr;
      req_cycle_type = vecs[k].types;
      req_wdat       = vecs[k].wdat;
      req_clk_en     = vecs[k].ce;
      @(negedge clk);
      chk("req_ready", k, 36'(req_ready),       36'(vecs[k].rdy));
      chk("hero_type", k, 36'(hero_cycle_type), 36'(vecs[k].ty));
      chk("hero_wdat", k, hero_wdat,            vecs[k].wd);
      chk("hero_cken", k, 36'(hero_clk_en),     36'(vecs[k].ceo));
      chk("txn_cnt",   k, 36'(txn_cnt),         36'(vecs[k].txn));
      chk("err_len",   k, 36'(err_len),         36'(vecs[k].el));
      chk("err_enc",   k, 36'(err_enc),         36'(vecs[k].ee));
      @(posedge clk);
      #1;
    end

    // Contention: requesters 0, 1, 3 stream 2-beat transactions back to back.
    rst            = 1'b1;
    req_cycle_type = '0;
    req_wdat       = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    rdy_s = '0;
    for (int i = 0; i < 4; i++) begin
      phase[i]  = 0;
      seq[i]    = 0;
      grants[i] = 0;
    end
    for (int cyc = 0; cyc < 60 && bt_wd.size() < 8; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        if (rdy_s[i]) begin
          if (phase[i] == 1) begin
            phase[i] = 0;
            seq[i]++;
          end else begin
            phase[i] = 1;
          end
        end
      end
      req_cycle_type = '0;
      req_wdat       = '0;
      req_clk_en     = 4'b1011;
      hero_ready     = 1'b1;
      for (int i = 0; i < 4; i++) begin
        if (i == 2) continue;
        req_cycle_type[4*i +: 4] = (phase[i] == 1) ? 4'd2 : 4'd1;
        req_wdat[36*i +: 36]     = {4'(i), 24'(seq[i]), 8'(phase[i])};
      end
      @(negedge clk);
      rdy_s = req_ready;
      if (hero_cycle_type != 4'd0) begin
        bt_ty.push_back(hero_cycle_type);
        bt_wd.push_back(hero_wdat);
      end
      @(posedge clk);
      #1;
    end
    req_cycle_type = '0;

    chk("rr_beats", 0, 36'(bt_wd.size()), 36'd8);
    for (int t = 0; t < 4; t++) begin
      for (int b = 0; b < 2; b++) begin
        if (2*t + b < bt_wd.size()) begin
          chk("rr_type", 2*t + b, 36'(bt_ty[2*t + b]), (b == 1) ? 36'd2 : 36'd1);
          chk("rr_wdat", 2*t + b, bt_wd[2*t + b],
              {4'(exp_own[t]), 24'(grants[exp_own[t]]), 8'(b)});
        end
      end
      grants[exp_own[t]]++;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hero_write_arbiter.md
# hero_write_arbiter

Round-robin arbiter that shares one hero write bus among `NUM_REQ` requesters, granting whole transactions rather than individual beats. Each requester drives a hero write beat: cycle type, 36-bit write data and clock enable. The arbiter locks a grant from the first beat through the DONE beat and forwards beats through one registered output stage that honours downstream backpressure. It also keeps a wrapping transaction counter and sticky error flags for malformed traffic.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..16.
- `MAX_BEATS`, default 16: maximum beats per transaction, including DONE.

Ports:
- `clk`  in  1: single clock. One clock; reset is synchronous and active-high.
- `rst`  in  1: synchronous, active-high reset.
- `req_cycle_type`  in  `NUM_REQ*4`: per-requester cycle type, slice i = `[4*i+3:4*i]`. Encoding: IDLE=0, VALID=1, DONE=2; all other codes are illegal.
- `req_wdat`  in  `NUM_REQ*36`: per-requester write data, width HERO_WIDTH=36.
- `req_clk_en`  in  `NUM_REQ`: per-requester clock enable.
- `req_ready`  out  `NUM_REQ`: beat accepted from requester i this cycle.
- `hero_cycle_type`  out  4: forwarded cycle type; IDLE means no beat.
- `hero_wdat`  out  36: forwarded data.
- `hero_clk_en`  out  1: forwarded clock enable.
- `hero_ready`  in  1: downstream accepts the current non-IDLE output beat.
- `txn_cnt`  out  16: count of DONE beats forwarded; wraps.
- `err_len`  out  1: sticky; a transaction reached `MAX_BEATS` without DONE.
- `err_enc`  out  1: sticky; the owner presented an illegal encoding.

## Operation
- State ARB:
  - All `req_ready` are 0.
  - A requester is pending when its cycle type is not IDLE.
  - If any requester is pending, pick a winner, register `owner`, and go to OWN.
- Winner selection: round-robin, searching from `last_owner+1` upward with wrap. `last_owner` resets to `NUM_REQ-1`, so requester 0 wins first.
- State OWN:
  - `req_ready[owner] = (hero_cycle_type==IDLE) || hero_ready`. All other `req_ready` are 0.
  - A beat transfers when the owner's type is not IDLE and its `req_ready` is 1.
  - An owner presenting IDLE is a stall. The grant is kept and nothing is loaded.
- Output register:
  - A VALID or DONE transfer loads type, data and clk_en into the output register.
  - If the output is non-IDLE, `hero_ready` is 1, and no new load occurs, the output type becomes IDLE. Data and clk_en hold their values.
- DONE transfer:
  - Go to ARB and set `last_owner <= owner`.
  - Beat counter returns to 0.
  - `txn_cnt` increments when the DONE beat is accepted downstream (output DONE and `hero_ready`=1). It wraps 0xFFFF -> 0.
- Beat counter: counts transfers in OWN, saturating at `MAX_BEATS`.
  - A VALID transfer that would make the count equal `MAX_BEATS` is forwarded as DONE instead.
  - That forced DONE sets `err_len` and ends the transaction.
- Illegal encoding from the owner:
  - `req_ready` is asserted and the beat is dropped (not forwarded, not counted).
  - `err_enc` is set and the state is unchanged.
- Illegal codes from non-owners are ignored, but count as pending in ARB.
- Reset:
  - State ARB, `owner`=0, `last_owner`=`NUM_REQ-1`.
  - `hero_cycle_type`=IDLE, `hero_wdat`=0, `hero_clk_en`=0.
  - `req_ready`=0, `txn_cnt`=0, `err_len`=0, `err_enc`=0.
  - Reset in the middle of a transaction abandons it; no DONE is emitted.

## Timing
- Arbitration takes one bubble cycle. A request first visible at cycle 0 (state ARB) gives `req_ready` at cycle 1, and the beat appears on `hero_*` at cycle 2.
- With `hero_ready` held at 1 and the owner streaming, throughput is one beat per cycle.
- After a DONE transfer at cycle n:
  - ARB at n+1.
  - Next owner's first `req_ready` at n+2.
  - Minimum gap between transactions on the bus: one IDLE cycle.
- If `hero_ready`=0 while the output is non-IDLE, `req_ready[owner]` is 0 and the output holds stable.
- A request that appears while the bus is in OWN is not sampled until the next ARB.

## Configuration
- `HERO_ARB_RR_EN` defined: round-robin selection as described above.
- `HERO_ARB_RR_EN` undefined: fixed priority; the lowest pending index always wins. `last_owner` is still maintained but unused.

## Test plan
- Single requester, with `hero_ready`=1:
  - Req 2 drives VALID x3 then DONE, data 0x1, 0x2, 0x3, 0xF00000000.
  - Output beats appear at cycles 2..5 in order, last beat DONE; `txn_cnt`=1.
- Contention under round-robin:
  - Reqs 0, 1 and 3 all request 2-beat transactions continuously.
  - Grant order is 0, 1, 3, 0; each transaction is unbroken by other requesters.
- Backpressure:
  - `hero_ready`=0 for 4 cycles in the middle of a transaction.
  - Output holds the same beat, `req_ready`=0, and no beats are lost or duplicated.
- Length limit with `MAX_BEATS`=4:
  - A requester sends 6 VALID beats.
  - The 4th beat is forwarded as DONE and `err_len`=1; the arbiter returns to ARB.
- Illegal encoding:
  - Owner drives type 3 for one cycle, then DONE.
  - The type-3 beat is dropped, `err_enc`=1, and the DONE is forwarded.
- Reset mid-transaction:
  - Assert `rst` after 2 beats.
  - Next cycle: all outputs at reset values, `txn_cnt`=0, and requester 0 wins first.
